or1200_enc_lsu_xor: RTL and testbench

OR1200_ENC_LSU_XOR -- requirements
Module: or1200_enc_lsu_xor

---
 rtl/or1200_enc_lsu_xor.sv | 265 ++++++++++++++++++++++++++
 tb/tb_or1200_enc_lsu_xor.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/or1200_enc_lsu_xor.sv
// ============================================================================
// or1200_enc_lsu_xor
// ----------------------------------------------------------------------------
// Encrypting load/store bridge between the OR1200 LSU and the data cache.
// Store data is XORed with a store pad before it reaches the cache. Load data
// returned by the cache is XORed with a load pad before it goes back to the
// pipeline. Pads come from an external generator and may arrive late, so the
// FSM can park in a wait state. If a pad does not arrive within PAD_TIMEOUT
// cycles, the access is aborted and an error pulse is raised.
//
// Parameters
//   PAD_TIMEOUT     maximum number of cycles spent waiting for a pad
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   req_i           LSU access request (held high until done_o)
//   we_i            1 = store, 0 = load
//   secure_i        access is encrypted with a pad
//   addr_i          access address
//   wdata_i         store plaintext
//   ld_pad_i        load pad value
//   ld_pad_valid_i  load pad available
//   st_pad_i        store pad value
//   st_pad_valid_i  store pad available
//   ld_pad_ack_o    load pad consumed this cycle
//   st_pad_ack_o    store pad consumed this cycle
//   dc_req_o        data-cache request
//   dc_we_o         data-cache write enable
//   dc_adr_o        data-cache address
//   dc_dat_o        data-cache write data (ciphertext)
//   dc_dat_i        data-cache read data (ciphertext)
//   dc_ack_i        data-cache acknowledge
//   rdata_o         load plaintext, held until the next load completes
//   done_o          one-cycle completion pulse
//   err_o           one-cycle pad-timeout pulse (always together with done_o)
//   stall_o         pipeline stall
// ============================================================================
module or1200_enc_lsu_xor #(
    parameter int PAD_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_i,
    input  logic        we_i,
    input  logic        secure_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,

    input  logic [31:0] ld_pad_i,
    input  logic        ld_pad_valid_i,
    input  logic [31:0] st_pad_i,
    input  logic        st_pad_valid_i,

    output logic        ld_pad_ack_o,
    output logic        st_pad_ack_o,

    output logic        dc_req_o,
    output logic        dc_we_o,
    output logic [31:0] dc_adr_o,
    output logic [31:0] dc_dat_o,
    input  logic [31:0] dc_dat_i,
    input  logic        dc_ack_i,

    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        err_o,
    output logic        stall_o
);

    // A timeout of 1 would need a zero-width counter, so keep at least one bit.
    localparam int              CNT_W    = (PAD_TIMEOUT > 1) ? $clog2(PAD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ST_WPAD = 3'd1,
        ST_REQ  = 3'd2,
        LD_REQ  = 3'd3,
        LD_WPAD = 3'd4,
        FIN     = 3'd5
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              sec_q, sec_n;
    logic [31:0]       wdata_q, wdata_n;
    logic [31:0]       raw_q, raw_n;

    logic              dc_req_n;
    logic              dc_we_n;
    logic [31:0]       dc_adr_n;
    logic [31:0]       dc_dat_n;
    logic [31:0]       rdata_n;
    logic              done_n;
    logic              err_n;
    logic              ld_ack;
    logic              st_ack;

    // Next-state and next-register logic. Every register defaults to holding
    // its value. Only the transitions named below change anything. Pad inputs
    // are looked at only in the states that can actually consume a pad, so a
    // stray pad_valid never produces an acknowledge.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        sec_n    = sec_q;
        wdata_n  = wdata_q;
        raw_n    = raw_q;
        dc_req_n = dc_req_o;
        dc_we_n  = dc_we_o;
        dc_adr_n = dc_adr_o;
        dc_dat_n = dc_dat_o;
        rdata_n  = rdata_o;
        done_n   = 1'b0;
        err_n    = 1'b0;
        ld_ack   = 1'b0;
        st_ack   = 1'b0;

        case (state)
            IDLE: begin
                if (req_i) begin
                    sec_n    = secure_i;
                    dc_adr_n = addr_i;
                    dc_we_n  = we_i;
                    if (we_i) begin
                        if (!secure_i || st_pad_valid_i) begin
                            dc_dat_n = wdata_i ^ (secure_i ? st_pad_i : 32'h0);
                            st_ack   = secure_i;
                            dc_req_n = 1'b1;
                            state_n  = ST_REQ;
                        end else begin
                            // Keep the plaintext in a private register so
                            // it never appears on the cache bus unencrypted.
                            wdata_n  = wdata_i;
                            cnt_n    = '0;
                            state_n  = ST_WPAD;
                        end
                    end else begin
                        dc_req_n = 1'b1;
                        state_n  = LD_REQ;
                    end
                end
            end

            ST_WPAD: begin
                cnt_n = cnt + 1'b1;
                // A pad arriving on the last allowed cycle still wins.
                if (st_pad_valid_i) begin
                    dc_dat_n = wdata_q ^ st_pad_i;
                    st_ack   = 1'b1;
                    dc_req_n = 1'b1;
                    state_n  = ST_REQ;
                end else if (cnt == CNT_LAST) begin
                    dc_we_n  = 1'b0;
                    done_n   = 1'b1;
                    err_n    = 1'b1;
                    state_n  = FIN;
                end
            end

            ST_REQ: begin
                if (dc_ack_i) begin
                    dc_req_n = 1'b0;
                    dc_we_n  = 1'b0;
                    done_n   = 1'b1;
                    state_n  = FIN;
                end
            end

            LD_REQ: begin
                if (dc_ack_i) begin
                    dc_req_n = 1'b0;
                    dc_we_n  = 1'b0;
                    if (!sec_q) begin
                        rdata_n = dc_dat_i;
                        done_n  = 1'b1;
                        state_n = FIN;
                    end else if (ld_pad_valid_i) begin
                        rdata_n = dc_dat_i ^ ld_pad_i;
                        ld_ack  = 1'b1;
                        done_n  = 1'b1;
                        state_n = FIN;
                    end else begin
                        // Cache data is only valid during the ack cycle, so
                        // keep the ciphertext until the pad shows up.
                        raw_n   = dc_dat_i;
                        cnt_n   = '0;
                        state_n = LD_WPAD;
                    end
                end
            end

            LD_WPAD: begin
                cnt_n = cnt + 1'b1;
                if (ld_pad_valid_i) begin
                    rdata_n = raw_q ^ ld_pad_i;
                    ld_ack  = 1'b1;
                    done_n  = 1'b1;
                    state_n = FIN;
                end else if (cnt == CNT_LAST) begin
                    done_n  = 1'b1;
                    err_n   = 1'b1;
                    state_n = FIN;
                end
            end

            FIN: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers. The reset is synchronous, so an access in
    // flight is simply dropped. Any late cache ack then lands in IDLE, which
    // ignores it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sec_q    <= 1'b0;
            wdata_q  <= 32'h0;
            raw_q    <= 32'h0;
            dc_req_o <= 1'b0;
            dc_we_o  <= 1'b0;
            dc_adr_o <= 32'h0;
            dc_dat_o <= 32'h0;
            rdata_o  <= 32'h0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            sec_q    <= sec_n;
            wdata_q  <= wdata_n;
            raw_q    <= raw_n;
            dc_req_o <= dc_req_n;
            dc_we_o  <= dc_we_n;
            dc_adr_o <= dc_adr_n;
            dc_dat_o <= dc_dat_n;
            rdata_o  <= rdata_n;
            done_o   <= done_n;
            err_o    <= err_n;
        end
    end

    // The pad acknowledges mark the cycle in which the pad is consumed. This
    // lets the pad generator advance on the same edge the pad is latched, so
    // they are combinational and are gated off during reset.
    always_comb begin
        ld_pad_ack_o = ld_ack & ~rst;
        st_pad_ack_o = st_ack & ~rst;
    end

    // Stall while a request waits in IDLE or any access is in progress. FIN
    // releases the pipeline in the same cycle that done_o is seen.
    always_comb begin
        stall_o = (req_i && (state == IDLE)) || ((state != IDLE) && (state != FIN));
    end

endmodule

// File: tb/tb_or1200_enc_lsu_xor.sv
// ============================================================================
// tb_or1200_enc_lsu_xor
// ----------------------------------------------------------------------------
// Scoreboard bench for or1200_enc_lsu_xor. The driver issues accesses and
// plays the roles of the cache and the pad generators. For each access it
// pushes the expected cache transaction and the expected completion, derived
// from the access rules:
//   ciphertext = plaintext ^ pad
//   a pad that is more than PAD_TIMEOUT cycles late gives an error
// A monitor pops those expectations whenever the DUT handshakes with the cache
// or signals done.
// ============================================================================
module tb_or1200_enc_lsu_xor;

    localparam int PT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i, we_i, secure_i;
    logic [31:0] addr_i, wdata_i;
    logic [31:0] ld_pad_i, st_pad_i;
    logic        ld_pad_valid_i, st_pad_valid_i;
    logic        ld_pad_ack_o, st_pad_ack_o;
    logic        dc_req_o, dc_we_o;
    logic [31:0] dc_adr_o, dc_dat_o, dc_dat_i;
    logic        dc_ack_i;
    logic [31:0] rdata_o;
    logic        done_o, err_o, stall_o;

    always #5 clk = ~clk;

    or1200_enc_lsu_xor #(.PAD_TIMEOUT(PT)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req_i),
        .we_i           (we_i),
        .secure_i       (secure_i),
        .addr_i         (addr_i),
        .wdata_i        (wdata_i),
        .ld_pad_i       (ld_pad_i),
        .ld_pad_valid_i (ld_pad_valid_i),
        .st_pad_i       (st_pad_i),
        .st_pad_valid_i (st_pad_valid_i),
        .ld_pad_ack_o   (ld_pad_ack_o),
        .st_pad_ack_o   (st_pad_ack_o),
        .dc_req_o       (dc_req_o),
        .dc_we_o        (dc_we_o),
        .dc_adr_o       (dc_adr_o),
        .dc_dat_o       (dc_dat_o),
        .dc_dat_i       (dc_dat_i),
        .dc_ack_i       (dc_ack_i),
        .rdata_o        (rdata_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .stall_o        (stall_o)
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } cache_exp_t;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          stAcks;
        int          ldAcks;
    } done_exp_t;

    cache_exp_t  cacheQ[$];
    done_exp_t   doneQ[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] modelRdata = 32'h0;
    int          stAckCnt = 0;
    int          ldAckCnt = 0;
    cache_exp_t  monCe;
    done_exp_t   monDe;

    // Compare one value against its expectation and report any difference.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: sample on the falling edge. Pop a cache expectation on every
    // request/ack handshake and a completion expectation on every done pulse.
    // Pad acknowledges are counted between completions.
    always @(negedge clk) begin
        if (rst) begin
            stAckCnt = 0;
            ldAckCnt = 0;
        end else begin
            if (st_pad_ack_o) stAckCnt++;
            if (ld_pad_ack_o) ldAckCnt++;
            if (dc_req_o && dc_ack_i) begin
                if (cacheQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_cache_access: got addr 0x%08h, expected no access", dc_adr_o);
                end else begin
                    monCe = cacheQ.pop_front();
                    checkOutput("dc_we", 32'(dc_we_o), 32'(monCe.we));
                    checkOutput("dc_adr", dc_adr_o, monCe.addr);
                    if (monCe.we) checkOutput("dc_dat", dc_dat_o, monCe.data);
                end
            end
            if (err_o && !done_o) begin
                checks++;
                errors++;
                $display("[TB] FAIL err_without_done: got err=1 done=0, expected err only with done");
            end
            if (done_o) begin
                if (doneQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done=1, expected no completion");
                end else begin
                    monDe = doneQ.pop_front();
                    checkOutput("err", 32'(err_o), 32'(monDe.err));
                    checkOutput("rdata", rdata_o, monDe.rdata);
                    checkOutput("st_pad_acks", 32'(stAckCnt), 32'(monDe.stAcks));
                    checkOutput("ld_pad_acks", 32'(ldAckCnt), 32'(monDe.ldAcks));
                end
                stAckCnt = 0;
                ldAckCnt = 0;
            end
        end
    end

    // Issue one access and play cache and pad generator until done_o.
    //   lat      = cycles the cache waits before acking (0 = ack at once)
    //   padDelay = cycles the pad is late:
    //                stores: counted from the accept cycle
    //                loads:  counted from the cache ack
    // The expected results and the completion cycle come from the access rules.
    task automatic applyStimulus(input bit we, input bit sec, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] pad,
                                 input logic [31:0] cdata, input int lat, input int padDelay);
        cache_exp_t ce;
        done_exp_t  de;
        bit         timeout, padOk, seen;
        int         cyc, reqCycles, ackCyc, expFin;

        timeout = sec && (padDelay > PT);
        ce.we   = we;
        ce.addr = addr;
        ce.data = sec ? (wdata ^ pad) : wdata;
        if (we) begin
            if (!timeout) cacheQ.push_back(ce);
            de.stAcks = (sec && !timeout) ? 1 : 0;
            de.ldAcks = 0;
            if (timeout)               expFin = PT + 1;
            else if (sec && padDelay > 0) expFin = padDelay + lat + 2;
            else                       expFin = lat + 2;
        end else begin
            cacheQ.push_back(ce);
            if (!sec)          modelRdata = cdata;
            else if (!timeout) modelRdata = cdata ^ pad;
            de.stAcks = 0;
            de.ldAcks = (sec && !timeout) ? 1 : 0;
            if (!sec || padDelay == 0) expFin = lat + 2;
            else if (timeout)          expFin = lat + 2 + PT;
            else                       expFin = lat + 2 + padDelay;
        end
        de.err   = timeout;
        de.rdata = modelRdata;
        doneQ.push_back(de);

        req_i    = 1'b1;
        we_i     = we;
        secure_i = sec;
        addr_i   = addr;
        wdata_i  = wdata;
        cyc       = done_o ? -1 : 0;
        reqCycles = 0;
        ackCyc    = -1;
        seen      = 1'b0;

        while (cyc <= expFin + 8) begin
            dc_ack_i = 1'b0;
            dc_dat_i = $urandom;
            if (dc_req_o) begin
                if (reqCycles == lat) begin
                    dc_ack_i = 1'b1;
                    dc_dat_i = cdata;
                    ackCyc   = cyc;
                end
                reqCycles++;
            end
            if (we) padOk = sec && (cyc >= padDelay);
            else    padOk = sec && (ackCyc >= 0) && (cyc - ackCyc >= padDelay);
            if (we) begin
                st_pad_valid_i = sec ? padOk : 1'($urandom_range(0, 1));
                st_pad_i       = padOk ? pad : $urandom;
                ld_pad_valid_i = 1'($urandom_range(0, 1));
                ld_pad_i       = $urandom;
            end else begin
                ld_pad_valid_i = sec ? padOk : 1'($urandom_range(0, 1));
                ld_pad_i       = padOk ? pad : $urandom;
                st_pad_valid_i = 1'($urandom_range(0, 1));
                st_pad_i       = $urandom;
            end
            #1;
            checkOutput("stall", 32'(stall_o), 32'(cyc >= 0));
            @(posedge clk);
            #1;
            cyc++;
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end

        checks++;
        if (!seen || cyc != expFin) begin
            errors++;
            $display("[TB] FAIL done_latency: got cycle %0d (seen=%0d), expected cycle %0d", cyc, seen, expFin);
        end

        req_i          = 1'b0;
        dc_ack_i       = 1'b0;
        st_pad_valid_i = 1'b0;
        ld_pad_valid_i = 1'b0;
    endtask

    // Hold reset for two edges and check that every output is cleared.
    task automatic resetAndCheck();
        rst            = 1'b1;
        req_i          = 1'b0;
        we_i           = 1'b0;
        secure_i       = 1'b0;
        addr_i         = 32'h0;
        wdata_i        = 32'h0;
        ld_pad_i       = 32'h0;
        st_pad_i       = 32'h0;
        ld_pad_valid_i = 1'b0;
        st_pad_valid_i = 1'b0;
        dc_dat_i       = 32'h0;
        dc_ack_i       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_dc_req", 32'(dc_req_o), 32'h0);
        checkOutput("rst_dc_we", 32'(dc_we_o), 32'h0);
        checkOutput("rst_dc_adr", dc_adr_o, 32'h0);
        checkOutput("rst_dc_dat", dc_dat_o, 32'h0);
        checkOutput("rst_rdata", rdata_o, 32'h0);
        checkOutput("rst_done", 32'(done_o), 32'h0);
        checkOutput("rst_err", 32'(err_o), 32'h0);
        checkOutput("rst_ld_ack", 32'(ld_pad_ack_o), 32'h0);
        checkOutput("rst_st_ack", 32'(st_pad_ack_o), 32'h0);
        checkOutput("rst_stall", 32'(stall_o), 32'h0);
        rst        = 1'b0;
        modelRdata = 32'h0;
    endtask

    // Start a secure load and reset it while the cache request is pending.
    // Then give the late ack: nothing may complete and all outputs stay clear.
    task automatic resetMidAccess();
        req_i    = 1'b1;
        we_i     = 1'b0;
        secure_i = 1'b1;
        addr_i   = 32'h0000_0500;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_dc_req_before", 32'(dc_req_o), 32'h1);
        rst   = 1'b1;
        req_i = 1'b0;
        @(posedge clk);
        #1;
        rst            = 1'b0;
        dc_ack_i       = 1'b1;
        dc_dat_i       = 32'h1357_9BDF;
        ld_pad_valid_i = 1'b1;
        ld_pad_i       = 32'hFFFF_FFFF;
        #1;
        checkOutput("mid_rst_ld_ack", 32'(ld_pad_ack_o), 32'h0);
        @(posedge clk);
        #1;
        dc_ack_i       = 1'b0;
        ld_pad_valid_i = 1'b0;
        checkOutput("mid_rst_dc_req", 32'(dc_req_o), 32'h0);
        checkOutput("mid_rst_dc_adr", dc_adr_o, 32'h0);
        checkOutput("mid_rst_rdata", rdata_o, 32'h0);
        checkOutput("mid_rst_done", 32'(done_o), 32'h0);
        checkOutput("mid_rst_stall", 32'(stall_o), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("mid_rst_done_late", 32'(done_o), 32'h0);
        modelRdata = 32'h0;
    endtask

    initial begin
        resetAndCheck();
        @(posedge clk);
        #1;

        // Plain store, ack after two wait cycles.
        applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'hA5A5_A5A5, 32'h0, 32'h0, 2, 0);
        // Secure store with the pad ready at accept.
        applyStimulus(1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 32'hFFFF_0000, 32'h0, 1, 0);
        // Secure load, pad three cycles after the ack.
        applyStimulus(1'b0, 1'b1, 32'h0000_0300, 32'h0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 1, 3);
        // Secure store whose pad never comes in time.
        applyStimulus(1'b1, 1'b1, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0000_1234, 32'h0, 0, PT + 5);
        // Pad arriving exactly on the last allowed cycle, store and load.
        applyStimulus(1'b1, 1'b1, 32'h0000_0404, 32'hCAFE_F00D, 32'h0F0F_00FF, 32'h0, 0, PT);
        applyStimulus(1'b0, 1'b1, 32'h0000_0408, 32'h0, 32'h5555_AAAA, 32'h1234_4321, 0, PT);
        // Secure load that times out: rdata must keep the previous value.
        applyStimulus(1'b0, 1'b1, 32'h0000_040C, 32'h0, 32'h1111_1111, 32'h8765_4321, 2, PT + 1);
        // Zero-latency plain loads issued back to back.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 32'h0000_0600 + 32'(i * 4), 32'h0, 32'h0, 32'hB000_0000 + 32'(i), 0, 0);

        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        resetMidAccess();

        for (int n = 0; n < 200; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                          $urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, PT + 2)));
            if ($urandom_range(0, 1) == 1) begin
                for (int g = 0; g < int'($urandom_range(1, 2)); g++) begin
                    @(posedge clk);
                    #1;
                end
            end
        end

        repeat (4) @(posedge clk);
        #1;
        checkOutput("cache_queue_drained", 32'(cacheQ.size()), 32'h0);
        checkOutput("done_queue_drained", 32'(doneQ.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Last-resort bound in case the DUT stops responding altogether.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before 2 ms");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
